uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync2.sv | 32 +++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default frame geometry.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input (RX, CTS).
// RST_VAL sets the value both flops take during reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled 8N1-style deserialiser with framing-error flag.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_clk_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_tick,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0]    AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0]    AFTER_DATA = ST_STOP;
`endif

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 serr_q, serr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 sample;
`ifdef UART_RX_PARITY_EN
  logic                 perr_pend_q, perr_pend_d;
  logic                 perr_q, perr_d;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // Counting restarts from mid start bit, so every full period lands mid-bit.
  assign sample = baud_clk_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    serr_d  = serr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_pend_d = perr_pend_q;
    perr_d      = 1'b0;
`endif
    if (baud_clk_tick && state_q != ST_IDLE) tick_d = tick_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end
      ST_START: begin
        if (baud_clk_tick && tick_q == TICK_HALF) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample) begin
          tick_d  = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            serr_d  = 1'b0;
            state_d = AFTER_DATA;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample) begin
          tick_d      = '0;
          perr_pend_d = ((^shreg_q) ^ rx_s) != 1'(PARITY_ODD);
          state_d     = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be seen in IDLE.
        if (sample) begin
          tick_d = '0;
          serr_d = serr_q | ~rx_s;
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = ST_IDLE;
            data_d  = shreg_q;
            done_d  = 1'b1;
            ferr_d  = serr_q | ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = perr_pend_q;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      serr_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      serr_q  <= serr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign rx_data      = data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven tick-by-tick, received
// bytes collected by a monitor and compared against a frame-level model.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_RX_PARITY_EN
  localparam int   PB   = 1;
  localparam logic PODD = 1'b0;
`else
  localparam int   PB   = 0;
  localparam logic PODD = 1'b0;
`endif
  localparam int FRAME_BITS = 1 + DB + PB + SB;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          baud_tick = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_done_tick, frame_err, rx_busy;
  logic          perr_now;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  assign perr_now = parity_err;
`else
  assign perr_now = 1'b0;
`endif

  int   errors = 0;
  int   checks = 0;
  int   tick_div = 163;
  int   tick_cnt = 0;
  int   stray = 0;
  obs_t obs_q[$];
  obs_t exp_q[$];

  uart_rx #(.DATA_BITS(DB), .STOP_BITS(SB), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .baud_clk_tick (baud_tick),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_done_tick  (rx_done_tick),
    .frame_err     (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err    (parity_err),
`endif
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt  <= 0;
      baud_tick <= 1'b1;
    end else begin
      tick_cnt  <= tick_cnt + 1;
      baud_tick <= 1'b0;
    end
  end

  always @(negedge clk) begin
    obs_t o;
    if (rx_done_tick === 1'b1) begin
      o.data = rx_data;
      o.ferr = frame_err;
      o.perr = perr_now;
      obs_q.push_back(o);
    end else if (frame_err !== 1'b0 || perr_now !== 1'b0) begin
      stray++;
    end
  end

  // Frame-level reference: what the receiver should report for a frame.
  function automatic obs_t exp_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    obs_t e;
    e.data = d;
    e.ferr = ~stop_v;
    e.perr = (PB == 1) ? (((^d) ^ par_v) != PODD) : 1'b0;
    return e;
  endfunction

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PODD;
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(OS);
  endtask

  // A low stop bit is released shortly after mid-bit so the line is idle again.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (PB == 1) send_bit(par_v);
    for (int s = 0; s < SB; s++) begin
      if (stop_v) send_bit(1'b1);
      else begin
        rx = 1'b0;
        wait_ticks(OS / 2 + 2);
        rx = 1'b1;
        wait_ticks(OS / 2 - 2);
      end
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", rx_done_tick); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_frame_55();
    obs_t e;
    obs_q.delete();
    e = exp_frame(8'h55, 1'b1, good_par(8'h55));
    send_frame(8'h55, 1'b1, good_par(8'h55));
    wait_ticks(OS);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL f55_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== e) begin errors++; $display("FAIL f55_frame: got %h expected %h", obs_q[0], e); end
    end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL f55_busy: got %b expected 0", rx_busy); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL f55_hold: got %h expected 55", rx_data); end
  endtask

  task automatic test_stop_err();
    obs_t e;
    obs_q.delete();
    e = exp_frame(8'hA3, 1'b0, good_par(8'hA3));
    send_frame(8'hA3, 1'b0, good_par(8'hA3));
    wait_ticks(OS);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== e) begin errors++; $display("FAIL ferr_frame: got %h expected %h", obs_q[0], e); end
    end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_glitch();
    obs_q.delete();
    rx = 1'b0;
    wait_ticks(2);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b expected 1", rx_busy); end
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(OS / 2);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b expected 0", rx_busy); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_done: got %0d pulses expected 0", obs_q.size()); end
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL glitch_hold: got %h expected a3", rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h81;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_frame(seq[i], 1'b1, good_par(seq[i])));
      send_frame(seq[i], 1'b1, good_par(seq[i]));
    end
    wait_ticks(OS);
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t       e;
    logic [7:0] d;
    d = 8'h3C;
    obs_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_hi: got %b expected 1", rx_busy); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_lo: got %b expected 0", rx_busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", rx_data); end
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_ticks(OS * 6);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rst_mid_nopulse: got %0d pulses expected 0", obs_q.size()); end
    e = exp_frame(8'hC3, 1'b1, good_par(8'hC3));
    send_frame(8'hC3, 1'b1, good_par(8'hC3));
    wait_ticks(OS);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL rst_c3_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== e) begin errors++; $display("FAIL rst_c3_frame: got %h expected %h", obs_q[0], e); end
    end
  endtask

  // Held low past one full frame, then released before the restarted start bit's midpoint.
  task automatic test_break();
    obs_t e;
    obs_q.delete();
    e = exp_frame(8'h00, 1'b0, 1'b0);
    rx = 1'b0;
    wait_ticks(OS / 2 + OS * (FRAME_BITS - 1) + 4);
    rx = 1'b1;
    wait_ticks(2 * OS);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL break_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== e) begin errors++; $display("FAIL break_frame: got %h expected %h", obs_q[0], e); end
    end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       sv, pv;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom_range(0, 255));
      sv = ($urandom_range(0, 3) != 0);
      pv = (PB == 1) ? 1'($urandom_range(0, 1)) : good_par(d);
      exp_q.push_back(exp_frame(d, sv, pv));
      send_frame(d, sv, pv);
    end
    wait_ticks(OS);
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL rand_count: got %0d expected 6", obs_q.size()); end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (rx_data !== exp_q[5].data) begin errors++; $display("FAIL rand_hold: got %h expected %h", rx_data, exp_q[5].data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    obs_q.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_ticks(OS);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL par_count: got %0d expected 2", obs_q.size()); end
    if (obs_q.size() > 1) begin
      checks++; if (obs_q[0].perr !== 1'b0) begin errors++; $display("FAIL par_good: got %b expected 0", obs_q[0].perr); end
      checks++; if (obs_q[1].perr !== 1'b1) begin errors++; $display("FAIL par_bad: got %b expected 1", obs_q[1].perr); end
      checks++; if (obs_q[1].data !== 8'h07) begin errors++; $display("FAIL par_data: got %h expected 07", obs_q[1].data); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_55();
    tick_div = 4;
    wait_ticks(4);
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (stray != 0) begin errors++; $display("FAIL stray_flags: got %0d expected 0", stray); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
